// File: rtl/hs32_wbuf.sv
// hs32_wbuf: posted write buffer between the hs32_cpu memory port and ext_sram.
// Optional read forwarding from the FIFO is enabled by defining WBUF_FWD_EN.
module hs32_wbuf #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_valid,
  input  logic        cpu_rw,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_dtw,
  output logic [31:0] cpu_dtr,
  output logic        cpu_ready,
  output logic        mem_valid,
  output logic        mem_rw,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_dtw,
  input  logic [31:0] mem_dtr,
  input  logic        mem_ready,
  output logic        wb_empty
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {C_IDLE, C_ACK, C_RDWAIT} c_state_t;
  typedef enum logic [1:0] {M_IDLE, M_WRITE, M_READ} m_state_t;

  c_state_t    c_state, c_next;
  m_state_t    m_state, m_next;
  wb_entry_t   fifo_q [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] count;
  logic        push, pop;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic        cpu_ready_d;
  logic [31:0] cpu_dtr_d;
  logic        mem_valid_d, mem_rw_d;
  logic [31:0] mem_addr_d, mem_dtw_d;

`ifdef WBUF_FWD_EN
  // Walk oldest to newest so the last match is the youngest write to that address.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((PW+1)'(k) < count && fifo_q[rd_ptr + PW'(k)].addr == cpu_addr) begin
        fwd_hit  = 1'b1;
        fwd_data = fifo_q[rd_ptr + PW'(k)].data;
      end
    end
  end
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

  // CPU side. cpu_ready is registered; the !cpu_ready guard keeps a request
  // still held during its own completion cycle from being accepted twice.
  always_comb begin
    c_next      = c_state;
    push        = 1'b0;
    cpu_ready_d = 1'b0;
    cpu_dtr_d   = cpu_dtr;
    case (c_state)
      C_IDLE: if (cpu_valid && !cpu_ready) begin
        if (cpu_rw) begin
          if (count != CNT_FULL) begin
            push        = 1'b1;
            cpu_ready_d = 1'b1;
            c_next      = C_ACK;
          end
        end else if (fwd_hit) begin
          cpu_dtr_d   = fwd_data;
          cpu_ready_d = 1'b1;
          c_next      = C_ACK;
        end else begin
          c_next = C_RDWAIT;
        end
      end
      C_ACK: c_next = C_IDLE;
      C_RDWAIT: if (m_state == M_READ && mem_ready) begin
        cpu_dtr_d   = mem_dtr;
        cpu_ready_d = 1'b1;
        c_next      = C_IDLE;
      end
      default: c_next = C_IDLE;
    endcase
  end

  // Mem side: queued writes always go before the stalled read.
  always_comb begin
    m_next      = m_state;
    pop         = 1'b0;
    mem_valid_d = mem_valid;
    mem_rw_d    = mem_rw;
    mem_addr_d  = mem_addr;
    mem_dtw_d   = mem_dtw;
    case (m_state)
      M_IDLE: if (count != '0) begin
        mem_valid_d = 1'b1;
        mem_rw_d    = 1'b1;
        mem_addr_d  = fifo_q[rd_ptr].addr;
        mem_dtw_d   = fifo_q[rd_ptr].data;
        m_next      = M_WRITE;
      end else if (c_state == C_RDWAIT) begin
        mem_valid_d = 1'b1;
        mem_rw_d    = 1'b0;
        mem_addr_d  = cpu_addr;
        m_next      = M_READ;
      end
      M_WRITE: if (mem_ready) begin
        pop         = 1'b1;
        mem_valid_d = 1'b0;
        m_next      = M_IDLE;
      end
      M_READ: if (mem_ready) begin
        mem_valid_d = 1'b0;
        m_next      = M_IDLE;
      end
      default: m_next = M_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_state   <= C_IDLE;
      m_state   <= M_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      cpu_ready <= 1'b0;
      cpu_dtr   <= '0;
      mem_valid <= 1'b0;
      mem_rw    <= 1'b0;
      mem_addr  <= '0;
      mem_dtw   <= '0;
    end else begin
      c_state   <= c_next;
      m_state   <= m_next;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count     <= count + (PW+1)'(push) - (PW+1)'(pop);
      cpu_ready <= cpu_ready_d;
      cpu_dtr   <= cpu_dtr_d;
      mem_valid <= mem_valid_d;
      mem_rw    <= mem_rw_d;
      mem_addr  <= mem_addr_d;
      mem_dtw   <= mem_dtw_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr] <= '{addr: cpu_addr, data: cpu_dtw};
  end

  assign wb_empty = (count == '0) && (m_state != M_WRITE);

endmodule

// File: tb/tb_hs32_wbuf.sv
// Self-checking bench for hs32_wbuf: table-driven CPU ops, an SRAM responder
// with a write scoreboard, and directed sequences for reset, full FIFO and forwarding.
module tb_hs32_wbuf;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_valid, cpu_rw;
  logic [31:0] cpu_addr, cpu_dtw, cpu_dtr;
  logic        cpu_ready;
  logic        mem_valid, mem_rw;
  logic [31:0] mem_addr, mem_dtw;
  logic [31:0] mem_dtr = '0;
  logic        mem_ready = 1'b0;
  logic        wb_empty;

  hs32_wbuf #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .cpu_valid(cpu_valid), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_dtw(cpu_dtw),
    .cpu_dtr(cpu_dtr), .cpu_ready(cpu_ready),
    .mem_valid(mem_valid), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_dtw(mem_dtw),
    .mem_dtr(mem_dtr), .mem_ready(mem_ready), .wb_empty(wb_empty)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_wr[$];
  logic [31:0] sram [logic [31:0]];

  function automatic logic [31:0] sram_rd(input logic [31:0] a);
    return sram.exists(a) ? sram[a] : ~a;
  endfunction

  // SRAM responder: acks after sram_lat cycles unless stalled; checks writes in order.
  bit sram_stall = 1'b0;
  int sram_lat = 0;
  int mem_wr_cnt = 0, mem_rd_cnt = 0, last_rdy_cyc = 0, mv_rise_cyc = 0;

  initial begin
    int   cnt;
    logic prev_mv;
    wr_t  e;
    cnt = 0;
    prev_mv = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        mem_ready = 1'b0;
        cnt = 0;
        prev_mv = 1'b0;
      end else begin
        if (mem_valid && !prev_mv) begin
          mv_rise_cyc = cyc;
          if (!mem_rw) chk("rd_after_drain", 32'(exp_wr.size()), 32'd0);
        end
        prev_mv = mem_valid;
        if (mem_ready) mem_ready = 1'b0;
        else if (mem_valid && !sram_stall) begin
          if (cnt >= sram_lat) begin
            cnt = 0;
            mem_ready = 1'b1;
            last_rdy_cyc = cyc;
            if (mem_rw) begin
              mem_wr_cnt++;
              if (exp_wr.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL wr_unexpected: got addr %h data %h expected no write", mem_addr, mem_dtw);
              end else begin
                e = exp_wr.pop_front();
                chk("wr_addr", mem_addr, e.addr);
                chk("wr_data", mem_dtw, e.data);
              end
              sram[mem_addr] = mem_dtw;
            end else begin
              mem_rd_cnt++;
              mem_dtr = sram_rd(mem_addr);
            end
          end else cnt++;
        end
      end
    end
  end

  task automatic cpu_op(input logic rw, input logic [31:0] a, input logic [31:0] d,
                        input int budget, output int lat, output logic [31:0] rdata,
                        output int rdy_cyc);
    @(negedge clk);
    cpu_valid = 1'b1;
    cpu_rw    = rw;
    cpu_addr  = a;
    cpu_dtw   = rw ? d : 32'h0;
    if (rw) exp_wr.push_back(wr_t'{a, d});
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!cpu_ready && lat < budget);
    if (!cpu_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL cpu_timeout: got no cpu_ready for addr %h after %0d cycles", a, lat);
    end
    rdata   = cpu_dtr;
    rdy_cyc = cyc;
    cpu_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((!wb_empty || exp_wr.size() != 0) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_wb_empty", 32'(wb_empty), 32'd1);
    chk("drain_queue", 32'(exp_wr.size()), 32'd0);
  endtask

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] data;
  } vec_t;

  vec_t        tbl [8];
  int          lat, rc, n, pop_cyc, lat5, rc5, wr_before, rd_before;
  logic [31:0] rd;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b1, 32'h10,  32'h1111};
    tbl[1] = '{1'b1, 32'h14,  32'h2222};
    tbl[2] = '{1'b0, 32'h10,  32'h1111};
    tbl[3] = '{1'b1, 32'h10,  32'h3333};
    tbl[4] = '{1'b0, 32'h10,  32'h3333};
    tbl[5] = '{1'b0, 32'h18,  32'hFFFF_FFE7};
    tbl[6] = '{1'b0, 32'h14,  32'h2222};
    tbl[7] = '{1'b0, 32'h100, 32'hDEAD_BEEF};

    cpu_valid = 1'b0; cpu_rw = 1'b0; cpu_addr = '0; cpu_dtw = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cpu_ready", 32'(cpu_ready), 32'd0);
    chk("rst_cpu_dtr", cpu_dtr, 32'd0);
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_mem_rw", 32'(mem_rw), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_dtw", mem_dtw, 32'd0);
    chk("rst_wb_empty", 32'(wb_empty), 32'd1);
    @(negedge clk);
    reset = 1'b0;

    // Single write, SRAM acks after 3 cycles
    sram_lat = 3;
    cpu_op(1'b1, 32'h100, 32'hDEAD_BEEF, 10, lat, rd, rc);
    chk("t2_wr_lat", 32'(lat), 32'd1);
    n = 0;
    do begin @(negedge clk); #1; n++; end while (!mem_ready && n < 20);
    chk("t2_mem_ready", 32'(mem_ready), 32'd1);
    chk("t2_mv_cyc", 32'(mv_rise_cyc), 32'(rc + 1));
    chk("t2_mem_rw", 32'(mem_rw), 32'd1);
    chk("t2_mem_addr", mem_addr, 32'h100);
    chk("t2_mem_dtw", mem_dtw, 32'hDEAD_BEEF);
    chk("t2_busy", 32'(wb_empty), 32'd0);
    @(posedge clk);
    #1;
    chk("t2_empty", 32'(wb_empty), 32'd1);

    // Table of mixed writes and reads
    sram_lat = 1;
    foreach (tbl[i]) begin
      cpu_op(tbl[i].rw, tbl[i].addr, tbl[i].data, 60, lat, rd, rc);
      if (tbl[i].rw) chk($sformatf("tbl%0d_wr_lat", i), 32'(lat), 32'd1);
      else           chk($sformatf("tbl%0d_rd_data", i), rd, tbl[i].data);
    end
    wait_drain(100);

    // Write then a missing read: read goes out only after the write drains
    sram_lat = 3;
    rd_before = mem_rd_cnt;
    cpu_op(1'b1, 32'h200, 32'h11, 10, lat, rd, rc);
    chk("t4_wr_lat", 32'(lat), 32'd1);
    cpu_op(1'b0, 32'h300, 32'h0, 60, lat, rd, rc);
    chk("t4_rd_data", rd, 32'hFFFF_FCFF);
    chk("t4_rd_ready_cyc", 32'(rc), 32'(last_rdy_cyc + 1));
    chk("t4_rd_cnt", 32'(mem_rd_cnt), 32'(rd_before + 1));

    // Fill the FIFO with SRAM stalled; the extra write waits for the first pop
    sram_stall = 1'b1;
    sram_lat = 0;
    for (int i = 0; i < DEPTH; i++) begin
      cpu_op(1'b1, 32'h1000 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 10, lat, rd, rc);
      chk($sformatf("t3_wr%0d_lat", i), 32'(lat), 32'd1);
    end
    pop_cyc = 0;
    fork
      cpu_op(1'b1, 32'h1010, 32'hC0DE_0004, 60, lat5, rd, rc5);
      begin
        int m;
        repeat (6) @(posedge clk);
        sram_stall = 1'b0;
        m = 0;
        do begin @(negedge clk); #1; m++; end while (!mem_ready && m < 20);
        pop_cyc = cyc;
      end
    join
    chk("t6_full_ack_cyc", 32'(rc5), 32'(pop_cyc + 2));
    wait_drain(200);
    cpu_op(1'b1, 32'h1004, 32'h55, 10, lat, rd, rc);
    cpu_op(0, 32'h1004, 32'h0, 60, lat, rd, rc);
    chk("t6_wrap_rd0", rd, 32'h55);
    cpu_op(0, 32'h1010, 32'h0, 60, lat, rd, rc);
    chk("t6_wrap_rd1", rd, 32'hC0DE_0004);

    // Reset mid-drain: queued writes never reach SRAM
    sram_stall = 1'b1;
    for (int i = 0; i < 3; i++) cpu_op(1'b1, 32'h500 + 32'(4 * i), 32'hBAD0 + 32'(i), 10, lat, rd, rc);
    chk("t1_mem_valid", 32'(mem_valid), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("t1_cpu_ready", 32'(cpu_ready), 32'd0);
    chk("t1_cpu_dtr", cpu_dtr, 32'd0);
    chk("t1_mem_valid_rst", 32'(mem_valid), 32'd0);
    chk("t1_mem_rw", 32'(mem_rw), 32'd0);
    chk("t1_mem_addr", mem_addr, 32'd0);
    chk("t1_mem_dtw", mem_dtw, 32'd0);
    chk("t1_wb_empty", 32'(wb_empty), 32'd1);
    exp_wr.delete();
    wr_before = mem_wr_cnt;
    @(negedge clk);
    reset = 1'b0;
    sram_stall = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("t1_no_writes", 32'(mem_wr_cnt), 32'(wr_before));
    chk("t1_idle", 32'(mem_valid), 32'd0);

    // Read of an address still in the FIFO
    sram_stall = 1'b1;
    sram_lat = 1;
    cpu_op(1'b1, 32'h40, 32'hAAAA, 10, lat, rd, rc);
    cpu_op(1'b1, 32'h40, 32'hBBBB, 10, lat, rd, rc);
    chk("t5_wr_lat", 32'(lat), 32'd1);
    rd_before = mem_rd_cnt;
`ifdef WBUF_FWD_EN
    cpu_op(1'b0, 32'h40, 32'h0, 10, lat, rd, rc);
    chk("t5_fwd_lat", 32'(lat), 32'd1);
    chk("t5_fwd_data", rd, 32'hBBBB);
    chk("t5_fwd_no_rd", 32'(mem_rd_cnt), 32'(rd_before));
    fork
      cpu_op(1'b0, 32'h44, 32'h0, 100, lat, rd, rc);
      begin repeat (5) @(posedge clk); sram_stall = 1'b0; end
    join
    chk("t5_miss_data", rd, 32'hFFFF_FFBB);
    chk("t5_miss_rd", 32'(mem_rd_cnt), 32'(rd_before + 1));
`else
    fork
      cpu_op(1'b0, 32'h40, 32'h0, 100, lat, rd, rc);
      begin repeat (5) @(posedge clk); sram_stall = 1'b0; end
    join
    chk("t5_rd_data", rd, 32'hBBBB);
    chk("t5_rd_waited", 32'(lat > 5), 32'd1);
    chk("t5_rd_cnt", 32'(mem_rd_cnt), 32'(rd_before + 1));
`endif
    wait_drain(100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
